spi_ram: RTL
============

# spi_ram

Single-port byte memory that sits directly downstream of the SPI slave. It consumes the slave's 10-bit `rx_data` words: a 2-bit command plus an 8-bit payload. It returns read bytes to the slave through `tx_data`/`tx_valid`, which the slave shifts out on MISO. The block holds separate write and read address pointers, with optional auto-increment, and flags read commands that are issued without a prior read address.

## Interface
Parameters:
- `MEM_DEPTH`, 256: number of 8-bit words.
- `ADDR_SIZE`, 8: pointer width; `MEM_DEPTH` ≤ 2^`ADDR_SIZE`.
- `AUTO_INC`, 1: 1 = pointer advances after each data write or read; 0 = pointer is static.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `din`  in  10: command word from the SPI slave `rx_data`; [9:8] = command, [7:0] = payload.
- `rx_valid`  in  1: `din` valid this cycle; one command per high cycle.
- `dout`  out  8: read byte to the SPI slave `tx_data`.
- `tx_valid`  out  1: one-cycle pulse; `dout` holds a new read byte.
- `cmd_err`  out  1: one-cycle pulse; command rejected.

## Operation
Reset (`rst_n` low, asynchronous):
- `dout`=0, `tx_valid`=0, `cmd_err`=0.
- Write pointer `wr_ptr`=0, read pointer `rd_ptr`=0, `rd_armed`=0.
- Memory contents are not reset.

Commands are decoded only on posedge `clk` with `rx_valid`=1. When `rx_valid`=0, `din` is ignored and no state changes except that the pulses return to 0.
- 00 WR_ADDR:
  - payload < `MEM_DEPTH`: `wr_ptr` ← payload.
  - Otherwise: `wr_ptr` is unchanged and `cmd_err` pulses.
- 01 WR_DATA:
  - mem[`wr_ptr`] ← payload.
  - If `AUTO_INC`: `wr_ptr` ← `wr_ptr`+1. It wraps from `MEM_DEPTH`-1 to 0.
- 10 RD_ADDR:
  - payload < `MEM_DEPTH`: `rd_ptr` ← payload and `rd_armed` ← 1.
  - Otherwise: `cmd_err` pulses, and `rd_ptr`/`rd_armed` are unchanged.
- 11 RD_DATA:
  - `rd_armed`=1: `dout` ← mem[`rd_ptr`] and `tx_valid` pulses. If `AUTO_INC`, `rd_ptr` ← `rd_ptr`+1 with the same wrap rule. The payload is ignored.
  - `rd_armed`=0: `cmd_err` pulses, and `dout`, `tx_valid` and `rd_ptr` are unchanged.
- `rd_armed` is cleared only by reset. Once armed, consecutive RD_DATA commands stream sequential bytes.
- Write and read pointers are independent. WR_ADDR never moves `rd_ptr`, and RD_ADDR never moves `wr_ptr`.
- `tx_valid` and `cmd_err` are never high in the same cycle.

## Timing
- Commands are sampled at edge N. Pointer and memory updates are visible after edge N.
- Read latency: RD_DATA sampled at edge N → `dout` and `tx_valid`=1 are valid after edge N. `tx_valid` falls after edge N+1 unless another RD_DATA is sampled at N+1.
- `dout` holds its last read value until the next successful RD_DATA or reset.
- `cmd_err` is asserted for the one cycle following the offending edge.
- Write-then-read: WR_DATA at edge N followed by RD_DATA at edge N+1 to the same address returns the new byte (write-first across cycles).
- Back-to-back `rx_valid` on every cycle is supported with no stalls. Each command completes in one cycle.
- Wrap-around: RD_DATA with `rd_ptr`=`MEM_DEPTH`-1 returns mem[`MEM_DEPTH`-1] and leaves `rd_ptr`=0.
- Reset asserted mid-operation: outputs go to 0 immediately, without waiting for a clock. Any `tx_valid` pulse in flight is dropped. Memory retains prior writes.
- Reset deassertion is synchronised by the system. The first command is accepted on the first posedge with `rst_n`=1.

## Test plan
- Reset check: drive `rst_n`=0 asynchronously between edges → `dout`=0x00, `tx_valid`=0 and `cmd_err`=0 immediately, and after deassert. A RD_DATA issued right after reset → `cmd_err` pulses and `tx_valid` stays 0.
- Basic write/read: WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA → `dout`=0xA5 with `tx_valid` high for exactly one cycle, one cycle after the RD_DATA edge.
- Auto-increment burst (`AUTO_INC`=1): WR_ADDR 0xFE, then WR_DATA 0x11, 0x22, 0x33 → mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33. RD_ADDR 0xFE followed by three RD_DATA → `dout` sequence 0x11, 0x22, 0x33.
- Back-to-back and pointer independence: WR_ADDR 0x05, RD_ADDR 0x40, WR_DATA 0x5A, RD_DATA, all on consecutive cycles with `rx_valid` held high → mem[0x05]=0x5A, and `dout`=mem[0x40] (not 0x5A).
- Out-of-range address (`MEM_DEPTH`=200): WR_ADDR 0xC8 → `cmd_err` pulses for one cycle and `wr_ptr` is unchanged. A subsequent WR_DATA 0x77 lands at the previous pointer.
- Reset mid-read: assert `rst_n` low in the cycle `tx_valid`=1 → `tx_valid` and `dout` go to 0 at once. After release, RD_ADDR and RD_DATA to a previously written address return the retained byte.

Source files
------------

// File: rtl/spi_ram_if.sv
// Command/response bundle between the SPI slave and spi_ram.
// The SPI slave is the master side; the memory is the slave side.
interface spi_ram_if;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       cmd_err;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  cmd_err
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output cmd_err
    );
endinterface

// File: rtl/spi_ram.sv
// Byte memory behind the SPI slave: decodes 2-bit commands with independent
// write/read pointers, optional auto-increment and a read-armed guard.
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter bit AUTO_INC  = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    spi_ram_if.slave bus
);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [7:0]           r_mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] r_wr_ptr;
    logic [ADDR_SIZE-1:0] r_rd_ptr;
    logic                 r_rd_armed;
    logic [7:0]           r_dout;
    logic                 r_tx_valid;
    logic                 r_cmd_err;

    cmd_e                 w_cmd;
    logic [7:0]           w_payload;
    logic [ADDR_SIZE-1:0] w_payload_addr;
    logic                 w_in_range;
    logic                 w_mem_we;
    logic [ADDR_SIZE-1:0] w_wr_ptr_nxt;
    logic [ADDR_SIZE-1:0] w_rd_ptr_nxt;
    logic                 w_rd_armed_nxt;
    logic [7:0]           w_dout_nxt;
    logic                 w_tx_valid_nxt;
    logic                 w_cmd_err_nxt;

    // Pointers wrap at MEM_DEPTH-1, which need not be a power of two.
    function automatic logic [ADDR_SIZE-1:0] advance(input logic [ADDR_SIZE-1:0] ptr);
        if (!AUTO_INC)
            return ptr;
        else if (ptr == LAST_ADDR)
            return '0;
        else
            return ptr + ADDR_SIZE'(1);
    endfunction

    assign w_cmd          = cmd_e'(bus.din[9:8]);
    assign w_payload      = bus.din[7:0];
    assign w_payload_addr = ADDR_SIZE'(w_payload);
    assign w_in_range     = (32'(w_payload) < 32'(MEM_DEPTH));

    always_comb begin
        w_mem_we       = 1'b0;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_rd_armed_nxt = r_rd_armed;
        w_dout_nxt     = r_dout;
        w_tx_valid_nxt = 1'b0;
        w_cmd_err_nxt  = 1'b0;
        if (bus.rx_valid) begin
            unique case (w_cmd)
                CMD_WR_ADDR: begin
                    if (w_in_range) w_wr_ptr_nxt  = w_payload_addr;
                    else            w_cmd_err_nxt = 1'b1;
                end
                CMD_WR_DATA: begin
                    w_mem_we     = 1'b1;
                    w_wr_ptr_nxt = advance(r_wr_ptr);
                end
                CMD_RD_ADDR: begin
                    if (w_in_range) begin
                        w_rd_ptr_nxt   = w_payload_addr;
                        w_rd_armed_nxt = 1'b1;
                    end else begin
                        w_cmd_err_nxt  = 1'b1;
                    end
                end
                CMD_RD_DATA: begin
                    if (r_rd_armed) begin
                        w_dout_nxt     = r_mem[r_rd_ptr];
                        w_tx_valid_nxt = 1'b1;
                        w_rd_ptr_nxt   = advance(r_rd_ptr);
                    end else begin
                        w_cmd_err_nxt  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_armed <= 1'b0;
            r_dout     <= '0;
            r_tx_valid <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_rd_armed <= w_rd_armed_nxt;
            r_dout     <= w_dout_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_cmd_err  <= w_cmd_err_nxt;
        end
    end

    // Storage is deliberately left out of reset so data survives a reset pulse.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_wr_ptr] <= w_payload;
    end

    assign bus.dout     = r_dout;
    assign bus.tx_valid = r_tx_valid;
    assign bus.cmd_err  = r_cmd_err;

endmodule
